div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the ALU and consumes the existing `prefix_adder` as its per-iteration subtractor. It accepts one operation at a time over a valid/ready handshake, runs a radix-2 restoring loop, and returns the quotient or remainder through a second valid/ready handshake.

---
 rtl/div_pkg.sv | 35 +++
 rtl/prefix_adder.sv | 47 ++++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   div_op_t    : RV32M divide/remainder operation encoding
//   div_state_t : divider FSM states
//   DIV_ITERS   : number of restoring iterations (one per quotient bit)
//   DIV_Q_BY_ZERO / DIV_INT_MIN : RISC-V special-case result values
package div_pkg;

  localparam int DIV_ITERS = 32;

  localparam logic [31:0] DIV_Q_BY_ZERO = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  function automatic logic op_is_signed(div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// prefix_adder: Kogge-Stone parallel-prefix adder.
//   a, b : addends          cin  : carry in
//   s    : sum (W bits)     cout : carry out of the top bit
module prefix_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int LVLS = $clog2(W);

  logic [W-1:0] p0;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] gn;
  logic [W-1:0] pn;

  assign p0 = a ^ b;

  // g[i] ends up as the carry out of bit i; cin is folded into bit 0's
  // generate so the prefix tree never needs a separate carry-in column.
  always_comb begin
    g    = a & b;
    p    = p0;
    g[0] = g[0] | (p0[0] & cin);
    gn   = g;
    pn   = p;
    for (int l = 0; l < LVLS; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
  end

  assign s    = p0 ^ {g[W-2:0], cin};
  assign cout = g[W-1];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : abort in-flight operation (only with DIV_FLUSH_EN)
//   in_valid/in_ready   : request handshake; op, dividend, divisor
//   out_valid/out_ready : result handshake; result
//   state_dbg           : current FSM state for observation
// Handshakes: a transfer happens on the rising edge where valid & ready are
// both high; valid is never withdrawn by this unit before that edge and
// result is held stable while out_valid is high.
// Build option: define DIV_FLUSH_EN to add the flush port.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef DIV_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  div_op_t         op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output div_state_t      state_dbg
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_t      state_q, state_d;
  div_op_t         op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CNT_W-1:0] cnt_q;

  logic            flush_w;
`ifdef DIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Request decode (only meaningful while IDLE)
  logic            accept, in_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign accept    = in_valid && (state_q == S_IDLE) && !flush_w;
  assign in_signed = op_is_signed(op);
  assign a_neg     = in_signed && dividend[XLEN-1];
  assign b_neg     = in_signed && divisor[XLEN-1];
  assign a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = in_signed && (dividend == DIV_INT_MIN) && (divisor == '1);
  assign special   = div_zero || ovf;
  assign special_res = op_is_rem(op) ? (div_zero ? dividend : '0)
                                     : (div_zero ? DIV_Q_BY_ZERO : DIV_INT_MIN);

  // Shared adder: trial subtraction in CALC, two's-complement negate in FIX.
  logic [XLEN-1:0] shifted, fix_sel, add_a, add_b, add_s;
  logic            add_cout, trial_ok, fix_neg;

  assign shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign fix_sel = op_is_rem(op_q) ? rem_q : quo_q;
  assign add_a   = (state_q == S_FIX) ? ~fix_sel : shifted;
  assign add_b   = (state_q == S_FIX) ? '0 : ~dvs_q;

  prefix_adder #(.W(XLEN)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b1),
    .s    (add_s),
    .cout (add_cout)
  );

  // rem_q[31] set means the 33-bit shifted value already exceeds any divisor.
  assign trial_ok = rem_q[XLEN-1] | add_cout;
  assign fix_neg  = op_is_signed(op_q) &&
                    (op_is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_w) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q     <= op;
          sign_a_q <= a_neg;
          sign_b_q <= b_neg;
          dvs_q    <= b_mag;
          rem_q    <= '0;
          quo_q    <= a_mag;
          cnt_q    <= CNT_W'(DIV_ITERS - 1);
          if (special) result_q <= special_res;
        end
        S_CALC: begin
          rem_q <= trial_ok ? add_s : shifted;
          quo_q <= {quo_q[XLEN-2:0], trial_ok};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: result_q <= fix_neg ? add_s : fix_sel;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        in_valid = 1'b0;
  logic        in_ready;
  div_op_t     op = OP_DIV;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  div_state_t  state_dbg;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DIV_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_div(input div_op_t o, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    logic is_rem, is_sgn;
    sa = a;
    sb = b;
    is_rem = (o == OP_REM) || (o == OP_REMU);
    is_sgn = (o == OP_DIV) || (o == OP_REM);
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input div_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic is_sgn;
    is_sgn = (o == OP_DIV) || (o == OP_REM);
    if (b == 0) return 1;
    if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request at a falling edge; it transfers on the next rising edge.
  // Returns positioned at the falling edge of cycle 1.
  task automatic start_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    exp_q.push_back(ref_div(o, a, b));
    lat_q.push_back(ref_lat(o, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;  // must be ignored outside IDLE
    divisor  = $urandom;
    check("busy_in_ready", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic finish_op(input int hold);
    int lat;
    logic [31:0] exp;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
    check("latency", 32'(lat), 32'(lat_q.pop_front()));
    exp = exp_q.pop_front();
    check("result", result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", result, exp);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b, input int hold);
    start_op(o, a, b);
    finish_op(hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    div_op_t     r_op;
    logic [31:0] r_a, r_b;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
    rst_n = 1'b1;

    run_op(OP_DIVU, 32'd100, 32'd7, 0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_DIV, 32'h1234_5678, 32'd0, 2);
    run_op(OP_REMU, 32'h1234_5678, 32'd0, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 10);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'd1, 0);

    // Randomized operations with a bias toward corner operands.
    for (int n = 0; n < 40; n++) begin
      r_op = div_op_t'(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0: r_a = $urandom;
        1: r_a = 32'($urandom_range(0, 200));
        2: r_a = 32'h8000_0000;
        default: r_a = -32'($urandom_range(1, 200));
      endcase
      case ($urandom_range(0, 4))
        0: r_b = 32'h0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_b = 32'($urandom_range(1, 20));
        3: r_b = -32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, $urandom_range(0, 3));
    end

`ifdef DIV_FLUSH_EN
    // Flush in cycle 10 of a long divide.
    start_op(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    check("flush_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("flush_no_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, 0);
`endif

    // Asynchronous reset in the middle of CALC discards the operation.
    start_op(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    check("arst_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
